fetch_stage: RTL and testbench



---
 rtl/pipeline_pkg.sv | 14 +
 rtl/sync_fifo.sv | 54 +++++
 rtl/fetch_stage.sv | 127 ++++++++++++
 tb/tb_fetch_stage.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Types and constants shared by the fetch, decode and hazard logic.
package pipeline_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with clear and occupancy count; dout shows the head entry.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (count != '0);
  // A full queue can still accept when its head leaves in the same cycle.
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns PCF, issues credit-limited in-order imem requests,
// buffers responses and drives the Decode-stage registers.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  StallD,
  input  logic                  FlushD,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  output logic [DATA_WIDTH-1:0] InstrD,
  output logic [DATA_WIDTH-1:0] PCD,
  output logic [DATA_WIDTH-1:0] PCPlus4D,
  output logic                  ValidD
);

  localparam int                    CW  = $clog2(DEPTH + 1);
  localparam int                    EW  = 2 * DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(NOP_INSTR);

  logic [DATA_WIDTH-1:0] pcf;
  logic [DATA_WIDTH-1:0] pend_pc;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         drop_cnt;
  logic [CW-1:0]         occupancy;
  logic [CW-1:0]         pend_count;
  logic [CW:0]           in_use;
  logic [EW-1:0]         rsp_entry;
  logic [EW-1:0]         head_entry;
  logic [EW-1:0]         dec_src;
  logic                  req_fire;
  logic                  rsp_accept;
  logic                  dec_load;
  logic                  q_empty;
  logic                  dec_has;

  // Every in-flight request is guaranteed a queue slot when it returns.
  assign in_use         = {1'b0, occupancy} + {1'b0, outstanding};
  assign imem_req_valid = rst_n && !PCSrcE && (in_use < (CW + 1)'(DEPTH));
  assign imem_req_addr  = pcf;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_accept = imem_rsp_valid && (drop_cnt == '0) && !PCSrcE;
  assign rsp_entry  = {pend_pc, imem_rsp_data};
  assign dec_load   = !StallD && !FlushD;
  assign q_empty    = (occupancy == '0);
  assign dec_src    = q_empty ? rsp_entry : head_entry;
  assign dec_has    = !q_empty || rsp_accept;

  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_pend_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_fire),
    .din   (pcf),
    .pop   (rsp_accept),
    .clear (PCSrcE),
    .dout  (pend_pc),
    .count (pend_count)
  );

  sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_instr_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rsp_accept && !(dec_load && q_empty)),
    .din   (rsp_entry),
    .pop   (dec_load && !q_empty),
    .clear (PCSrcE),
    .dout  (head_entry),
    .count (occupancy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcf <= RESET_PC;
    end else if (PCSrcE) begin
      pcf <= PCTargetE;
    end else if (req_fire) begin
      pcf <= pcf + DATA_WIDTH'(4);
    end
  end

  // On redirect everything still in flight becomes stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (PCSrcE) begin
      outstanding <= outstanding - CW'(imem_rsp_valid);
      drop_cnt    <= outstanding - CW'(imem_rsp_valid);
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      InstrD   <= NOP;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (FlushD || (dec_load && !dec_has)) begin
      InstrD   <= NOP;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (dec_load) begin
      {PCD, InstrD} <= dec_src;
      PCPlus4D      <= dec_src[EW-1 -: DATA_WIDTH] + DATA_WIDTH'(4);
      ValidD        <= 1'b1;
    end
  end

  a_credit_balance: assert property (@(posedge clk) disable iff (!rst_n)
    ({1'b0, pend_count} + {1'b0, drop_cnt}) == {1'b0, outstanding});

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: in-order memory model with random latency,
// expected program-order stream per redirect, monitor on the Decode registers.
module tb_fetch_stage;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        StallD = 1'b0;
  logic        FlushD = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;

  fetch_stage #(.DATA_WIDTH(32), .RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .StallD         (StallD),
    .FlushD         (FlushD),
    .PCSrcE         (PCSrcE),
    .PCTargetE      (PCTargetE),
    .InstrD         (InstrD),
    .PCD            (PCD),
    .PCPlus4D       (PCPlus4D),
    .ValidD         (ValidD)
  );

  initial forever #5 clk = ~clk;

  typedef struct { int unsigned due; logic [31:0] addr; } mem_req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  mem_req_t    mem_q[$];
  exp_t        exp_q[$];
  logic [31:0] log_pc[$];
  int unsigned log_cyc[$];

  int unsigned cyc = 0;
  int unsigned last_due = 0;
  int          tests = 0;
  int          failed = 0;
  logic [31:0] exp_pcf = RST_PC;

  bit          rand_mode = 0;
  int          rdy_mode = 0;
  bit          drv_ready = 0, drv_stall = 0, drv_flush = 0, drv_redir = 0;
  logic [31:0] drv_target = '0;
  int          lat_min = 1, lat_max = 1;
  bit          cur_stall = 0, cur_flush = 0, chk_redir_addr = 0, last_req_valid = 0;
  logic [31:0] last_target = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] base;
    case ($urandom_range(3))
      0:       base = 32'h0000_2000;
      1:       base = 32'h1000_0000;
      2:       base = 32'hFFFF_FFF4;
      default: base = 32'h0000_0040;
    endcase
    return base + ($urandom_range(7) << 2);
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string info);
    tests++;
    failed++;
    $display("FAIL %s: %s", name, info);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    PCSrcE = 1'b0; FlushD = 1'b0; StallD = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    mem_q.delete(); exp_q.delete();
    exp_pcf = RST_PC; last_due = cyc;
    cur_stall = 0; cur_flush = 0; chk_redir_addr = 0;
    #1;
    check("reset_outputs", {imem_req_valid, ValidD, InstrD, PCD, PCPlus4D, imem_req_addr},
          {1'b0, 1'b0, NOP, 32'h0, 32'h0, RST_PC});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("first_req", {imem_req_valid, imem_req_addr}, {1'b1, RST_PC});
  endtask

  // One cycle: memory response, stimulus, request handshake bookkeeping.
  task automatic step();
    mem_req_t    r;
    exp_t        e;
    int unsigned d;
    @(negedge clk);
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    if (rand_mode) begin
      StallD         = ($urandom_range(99) < 25);
      PCSrcE         = ($urandom_range(99) < 5);
      FlushD         = PCSrcE || ($urandom_range(99) < 8);
      PCTargetE      = rand_target();
      imem_req_ready = ($urandom_range(99) < 70);
    end else begin
      StallD         = drv_stall;
      PCSrcE         = drv_redir;
      FlushD         = drv_flush;
      PCTargetE      = drv_target;
      imem_req_ready = (rdy_mode == 1) ? cyc[0] : drv_ready;
    end
    #1;
    last_req_valid = imem_req_valid;
    if (chk_redir_addr) check("redirect_addr", imem_req_addr, last_target);
    chk_redir_addr = 0;
    if (PCSrcE) check("no_req_on_redirect", imem_req_valid, 0);
    if (imem_req_valid) check("req_addr", imem_req_addr, exp_pcf);
    if (imem_req_valid && imem_req_ready) begin
      d = cyc + $urandom_range(lat_max, lat_min);
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      r.due = d; r.addr = imem_req_addr;
      mem_q.push_back(r);
      e.pc = exp_pcf; e.instr = mem_word(exp_pcf);
      exp_q.push_back(e);
      exp_pcf = exp_pcf + 32'd4;
      check("inflight_limit", mem_q.size() <= DEPTH, 1);
    end
    if (PCSrcE) begin
      exp_q.delete();
      exp_pcf = PCTargetE;
      chk_redir_addr = 1;
      last_target = PCTargetE;
    end
    cur_stall = StallD;
    cur_flush = FlushD;
    @(posedge clk);
    cyc++;
  endtask

  // Monitor: pops the scoreboard whenever Decode loads a real instruction.
  initial begin
    logic [31:0] p_instr, p_pc, p_pc4;
    logic        p_valid;
    exp_t        e;
    p_instr = NOP; p_pc = '0; p_pc4 = '0; p_valid = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (rst_n) begin
        if (!ValidD) check("bubble", {InstrD, PCD, PCPlus4D}, {NOP, 32'h0, 32'h0});
        if (cur_flush) begin
          check("flush_bubble", ValidD, 0);
        end else if (cur_stall) begin
          check("stall_hold", {InstrD, PCD, PCPlus4D, ValidD}, {p_instr, p_pc, p_pc4, p_valid});
        end else if (ValidD) begin
          if (exp_q.size() == 0) begin
            fail_now("spurious_instr", $sformatf("got PCD %0h, expected no instruction", PCD));
          end else begin
            e = exp_q.pop_front();
            check("decode_entry", {PCD, InstrD, PCPlus4D}, {e.pc, e.instr, e.pc + 32'd4});
          end
          log_pc.push_back(PCD);
          log_cyc.push_back(cyc);
        end
      end
      p_instr = InstrD; p_pc = PCD; p_pc4 = PCPlus4D; p_valid = ValidD;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    failed++;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int idx;
    do_reset();

    // Streaming with a 1-cycle memory.
    drv_ready = 1; lat_min = 1; lat_max = 1;
    log_pc.delete(); log_cyc.delete();
    repeat (8) step();
    if (log_pc.size() >= 3) begin
      check("stream_order", {log_pc[0], log_pc[1], log_pc[2]}, {32'h1000, 32'h1004, 32'h1008});
      check("stream_rate", {log_cyc[1] - log_cyc[0], log_cyc[2] - log_cyc[1]}, {32'd1, 32'd1});
    end else begin
      fail_now("stream_count", $sformatf("got %0d instructions, expected at least 3", log_pc.size()));
    end

    // Decode stall fills the queue and stops requests.
    drv_stall = 1;
    repeat (3) step();
    check("stall_credit", last_req_valid, 0);
    drv_stall = 0;
    repeat (6) step();

    // Redirect with two responses in flight.
    lat_min = 3; lat_max = 3;
    n = 0;
    while (mem_q.size() != 2 && n < 20) begin
      step();
      n++;
    end
    if (n == 20) fail_now("two_in_flight", "timed out waiting for 2 outstanding requests");
    drv_redir = 1; drv_flush = 1; drv_target = 32'h0000_2000;
    step();
    drv_redir = 0; drv_flush = 0;
    log_pc.delete(); log_cyc.delete();
    repeat (12) step();
    if (log_pc.size() >= 1) check("redirect_first", log_pc[0], 32'h2000);
    else fail_now("redirect_first", "no instruction after redirect");

    // Slow memory with ready toggling, across the address wrap.
    drv_redir = 1; drv_flush = 1; drv_target = 32'hFFFF_FFF0;
    step();
    drv_redir = 0; drv_flush = 0; rdy_mode = 1;
    log_pc.delete(); log_cyc.delete();
    repeat (40) step();
    idx = -1;
    foreach (log_pc[i]) if (idx < 0 && log_pc[i] == 32'hFFFF_FFFC) idx = i;
    if (idx >= 0 && idx + 1 < log_pc.size()) check("pc_wrap", log_pc[idx + 1], 32'h0);
    else fail_now("pc_wrap", "0xFFFFFFFC and its successor not both seen");

    // FlushD wins over StallD and pops nothing.
    rdy_mode = 0; lat_min = 1; lat_max = 1;
    drv_stall = 1;
    repeat (4) step();
    drv_flush = 1;
    step();
    #1;
    check("flush_over_stall", {ValidD, InstrD, PCD}, {1'b0, NOP, 32'h0});
    drv_flush = 0; drv_stall = 0;
    repeat (6) step();

    // Random traffic, a mid-run reset, more random traffic.
    rand_mode = 1; lat_min = 1; lat_max = 4;
    repeat (600) step();
    do_reset();
    repeat (300) step();

    // Drain: no new requests; everything accepted must reach Decode.
    rand_mode = 0; drv_ready = 0; drv_stall = 0; drv_flush = 0; drv_redir = 0;
    repeat (25) step();
    check("drain_lost", exp_q.size(), 0);
    check("idle_credit", last_req_valid, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
